// File: rtl/pixel_sram_arbiter.sv
// Three-way arbiter granting whole ownership of the dual-port pixel SRAM to one
// requester at a time: round-robin selection, optional lock, hold limit under contention.
module pixel_sram_arbiter #(
  parameter int unsigned IMAGE_ADDR_WIDTH = 12,
  parameter int unsigned RGB_SIZE         = 8,
  parameter int unsigned MAX_HOLD         = 256
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [2:0]                    req,
  input  logic [2:0]                    lock,
  input  logic [3*IMAGE_ADDR_WIDTH-1:0] addr_a_in,
  input  logic [3*IMAGE_ADDR_WIDTH-1:0] addr_b_in,
  input  logic [3*RGB_SIZE-1:0]         wdata_a_in,
  input  logic [3*RGB_SIZE-1:0]         wdata_b_in,
  input  logic [2:0]                    rd_a_in,
  input  logic [2:0]                    rd_b_in,
  input  logic [2:0]                    wr_a_in,
  input  logic [2:0]                    wr_b_in,
  output logic [2:0]                    gnt,
  output logic [2:0]                    rvalid,
  output logic [RGB_SIZE-1:0]           rdata_a,
  output logic [RGB_SIZE-1:0]           rdata_b,
  output logic [IMAGE_ADDR_WIDTH-1:0]   address_a,
  output logic [IMAGE_ADDR_WIDTH-1:0]   address_b,
  output logic [RGB_SIZE-1:0]           data_a,
  output logic [RGB_SIZE-1:0]           data_b,
  output logic                          rden_a,
  output logic                          rden_b,
  output logic                          wren_a,
  output logic                          wren_b,
  input  logic [RGB_SIZE-1:0]           q_a,
  input  logic [RGB_SIZE-1:0]           q_b,
  output logic                          collision_err
);

  localparam int unsigned AddrW = IMAGE_ADDR_WIDTH;
  localparam int unsigned DataW = RGB_SIZE;
  localparam int unsigned HoldW = $clog2(MAX_HOLD + 1);

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e           state_q, state_d;
  logic [2:0]       gnt_q, gnt_d;
  logic [1:0]       rr_q, rr_d;
  logic [HoldW-1:0] hold_q, hold_d;
  logic [2:0]       rvalid_q, rvalid_d;
  logic             collision_q, collision_d;

  logic [1:0]       owner;
  logic [2:0]       others;
  logic             end_grant;
  logic [2:0]       pick;

  logic [AddrW-1:0] addr_a_sel, addr_b_sel;
  logic [DataW-1:0] data_a_sel, data_b_sel;
  logic             rd_a_sel, rd_b_sel, wr_a_sel, wr_b_sel;
  logic             coll;

  // One-hot of the first set candidate, searching upward (mod 3) from ptr.
  function automatic logic [2:0] rr_pick(input logic [2:0] cand, input logic [1:0] ptr);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int unsigned n = 0; n < 3; n++) begin
      idx = 2'((32'(ptr) + n) % 32'd3);
      if (res == 3'b000 && cand[idx]) res[idx] = 1'b1;
    end
    return res;
  endfunction

  // Owner index decoded from the registered one-hot grant.
  always_comb begin
    if (gnt_q[2])      owner = 2'd2;
    else if (gnt_q[1]) owner = 2'd1;
    else               owner = 2'd0;
  end

  // Grant FSM next state: arbitration, end-of-grant, hold limit.
  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    rr_d      = rr_q;
    hold_d    = hold_q;
    pick      = 3'b000;
    others    = req & ~gnt_q;
    end_grant = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (|req) begin
          gnt_d   = rr_pick(req, rr_q);
          hold_d  = '0;
          state_d = StBusy;
        end
      end
      StBusy: begin
        end_grant = !req[owner] || !lock[owner] ||
                    ((hold_q >= HoldW'(MAX_HOLD - 1)) && (|others));
        if (end_grant) begin
          rr_d    = (owner == 2'd2) ? 2'd0 : owner + 2'd1;
          pick    = rr_pick(others, rr_d);
          gnt_d   = pick;
          hold_d  = '0;
          state_d = (|pick) ? StBusy : StIdle;
        end else if (hold_q < HoldW'(MAX_HOLD - 1)) begin
          // Saturates so an uncontended lock never wraps back below the limit.
          hold_d = hold_q + 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
        gnt_d   = 3'b000;
      end
    endcase
  end

  // SRAM request mux: AND-OR of slices gated by the grant, so no owner means all zeros.
  always_comb begin
    addr_a_sel = '0;
    addr_b_sel = '0;
    data_a_sel = '0;
    data_b_sel = '0;
    rd_a_sel   = 1'b0;
    rd_b_sel   = 1'b0;
    wr_a_sel   = 1'b0;
    wr_b_sel   = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (gnt_q[i]) begin
        addr_a_sel = addr_a_sel | addr_a_in[i*AddrW +: AddrW];
        addr_b_sel = addr_b_sel | addr_b_in[i*AddrW +: AddrW];
        data_a_sel = data_a_sel | wdata_a_in[i*DataW +: DataW];
        data_b_sel = data_b_sel | wdata_b_in[i*DataW +: DataW];
        rd_a_sel   = rd_a_sel | rd_a_in[i];
        rd_b_sel   = rd_b_sel | rd_b_in[i];
        wr_a_sel   = wr_a_sel | wr_a_in[i];
        wr_b_sel   = wr_b_sel | wr_b_in[i];
      end
    end
    coll        = wr_a_sel && wr_b_sel && (addr_a_sel == addr_b_sel);
    // Read tag follows the owner of the read cycle, even if the grant moves on.
    rvalid_d    = (rd_a_sel || rd_b_sel) ? gnt_q : 3'b000;
    collision_d = collision_q | coll;
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      gnt_q       <= 3'b000;
      rr_q        <= 2'd0;
      hold_q      <= '0;
      rvalid_q    <= 3'b000;
      collision_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      rr_q        <= rr_d;
      hold_q      <= hold_d;
      rvalid_q    <= rvalid_d;
      collision_q <= collision_d;
    end
  end

  assign gnt           = gnt_q;
  assign rvalid        = rvalid_q;
  assign collision_err = collision_q;
  assign rdata_a       = q_a;
  assign rdata_b       = q_b;
  assign address_a     = addr_a_sel;
  assign address_b     = addr_b_sel;
  assign data_a        = data_a_sel;
  assign data_b        = data_b_sel;
  assign rden_a        = rd_a_sel;
  assign rden_b        = rd_b_sel;
  assign wren_a        = wr_a_sel;
  // Port A wins a same-address double write.
  assign wren_b        = wr_b_sel & ~coll;

endmodule

// File: tb/tb_pixel_sram_arbiter.sv
// Scoreboard bench for pixel_sram_arbiter: directed scenarios plus random traffic
// against a behavioural grant/memory model, with a separate read-response monitor.
module tb_pixel_sram_arbiter;

  localparam int AW   = 12;
  localparam int DW   = 8;
  localparam int MAXH = 256;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [2:0]      req, lock, rd_a_in, rd_b_in, wr_a_in, wr_b_in;
  logic [3*AW-1:0] addr_a_in, addr_b_in;
  logic [3*DW-1:0] wdata_a_in, wdata_b_in;
  logic [2:0]      gnt, rvalid;
  logic [DW-1:0]   rdata_a, rdata_b, data_a, data_b, q_a, q_b;
  logic [AW-1:0]   address_a, address_b;
  logic            rden_a, rden_b, wren_a, wren_b, collision_err;

  pixel_sram_arbiter #(
    .IMAGE_ADDR_WIDTH(AW),
    .RGB_SIZE        (DW),
    .MAX_HOLD        (MAXH)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req          (req),
    .lock         (lock),
    .addr_a_in    (addr_a_in),
    .addr_b_in    (addr_b_in),
    .wdata_a_in   (wdata_a_in),
    .wdata_b_in   (wdata_b_in),
    .rd_a_in      (rd_a_in),
    .rd_b_in      (rd_b_in),
    .wr_a_in      (wr_a_in),
    .wr_b_in      (wr_b_in),
    .gnt          (gnt),
    .rvalid       (rvalid),
    .rdata_a      (rdata_a),
    .rdata_b      (rdata_b),
    .address_a    (address_a),
    .address_b    (address_b),
    .data_a       (data_a),
    .data_b       (data_b),
    .rden_a       (rden_a),
    .rden_b       (rden_b),
    .wren_a       (wren_a),
    .wren_b       (wren_b),
    .q_a          (q_a),
    .q_b          (q_b),
    .collision_err(collision_err)
  );

  // Behavioural dual-port SRAM with registered read (environment, not the reference).
  logic [DW-1:0] sram [4096];
  always @(posedge clk) begin
    if (wren_a) sram[address_a] <= data_a;
    if (wren_b) sram[address_b] <= data_b;
    if (rden_a) q_a <= sram[address_a];
    if (rden_b) q_b <= sram[address_b];
  end

  int n_checks = 0;
  int n_errs   = 0;
  int cyc      = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model state.
  logic [DW-1:0] ref_mem [4096];
  int   m_owner;  // -1 when nobody owns the SRAM
  int   m_rr;
  int   m_hold;
  bit   m_col;
  logic [2:0] last_gnt;

  typedef struct {
    int          id;
    int          due;
    logic [DW-1:0] da;
    logic [DW-1:0] db;
    bit          ca;
    bit          cb;
  } rd_exp_t;
  rd_exp_t sb[$];

  task automatic model_reset();
    m_owner = -1;
    m_rr    = 0;
    m_hold  = 0;
    m_col   = 1'b0;
    sb.delete();
  endtask

  // Monitor: pops the scoreboard whenever a read response is due.
  rd_exp_t       mon_e;
  logic [2:0]    mon_ev;
  always @(negedge clk) begin
    if (!rst) begin
      mon_ev = 3'b000;
      if (sb.size() > 0 && sb[0].due == cyc) begin
        mon_e  = sb.pop_front();
        mon_ev = 3'(1 << mon_e.id);
        if (mon_e.ca) chk("rdata_a", 64'(rdata_a), 64'(mon_e.da));
        if (mon_e.cb) chk("rdata_b", 64'(rdata_b), 64'(mon_e.db));
      end
      chk("rvalid", 64'(rvalid), 64'(mon_ev));
    end
  end

  // One clock cycle: drive, check combinational SRAM side, advance model.
  task automatic step(input logic [2:0] r, input logic [2:0] l, input logic [2:0] ra,
                      input logic [2:0] rb, input logic [2:0] wa, input logic [2:0] wb,
                      input logic [3*AW-1:0] aa, input logic [3*AW-1:0] ab,
                      input logic [3*DW-1:0] da, input logic [3*DW-1:0] db);
    logic [AW-1:0] ea, eb;
    logic [DW-1:0] eda, edb;
    logic          era, erb, ewa, ewb, ecoll, ewb_eff;
    int            o, nxt, j;
    bit            oth;
    rd_exp_t       e;
    req = r; lock = l; rd_a_in = ra; rd_b_in = rb; wr_a_in = wa; wr_b_in = wb;
    addr_a_in = aa; addr_b_in = ab; wdata_a_in = da; wdata_b_in = db;
    @(negedge clk);
    ea = '0; eb = '0; eda = '0; edb = '0;
    era = 0; erb = 0; ewa = 0; ewb = 0;
    if (m_owner >= 0) begin
      o   = m_owner;
      ea  = aa[o*AW +: AW];  eb  = ab[o*AW +: AW];
      eda = da[o*DW +: DW];  edb = db[o*DW +: DW];
      era = ra[o]; erb = rb[o]; ewa = wa[o]; ewb = wb[o];
    end
    ecoll   = ewa && ewb && (ea == eb);
    ewb_eff = ewb && !ecoll;
    chk("gnt", 64'(gnt), (m_owner < 0) ? 64'd0 : 64'(1) << m_owner);
    chk("sram_ctl", 64'({rden_a, rden_b, wren_a, wren_b}), 64'({era, erb, ewa, ewb_eff}));
    chk("sram_addr", 64'({address_a, address_b}), 64'({ea, eb}));
    chk("sram_data", 64'({data_a, data_b}), 64'({eda, edb}));
    chk("collision_err", 64'(collision_err), 64'(m_col));
    last_gnt = gnt;
    if (!rst) begin
      if (m_owner >= 0 && (era || erb)) begin
        e.id  = m_owner;
        e.due = cyc + 1;
        e.da  = ref_mem[ea];
        e.db  = ref_mem[eb];
        // Same-cycle write to the read address leaves the read data undefined.
        e.ca  = era && !ewa && !(ewb_eff && eb == ea);
        e.cb  = erb && !ewb_eff && !(ewa && ea == eb);
        sb.push_back(e);
      end
      if (ewa)     ref_mem[ea] = eda;
      if (ewb_eff) ref_mem[eb] = edb;
      if (ecoll)   m_col = 1'b1;
    end
    // Grant rules: round robin from the pointer; lock keeps it; hold limit under contention.
    if (rst) begin
      model_reset();
    end else if (m_owner < 0) begin
      nxt = -1;
      for (int n = 0; n < 3; n++) begin
        j = (m_rr + n) % 3;
        if (nxt < 0 && r[j]) nxt = j;
      end
      m_owner = nxt;
      m_hold  = 0;
    end else begin
      o   = m_owner;
      oth = 0;
      for (int k = 0; k < 3; k++) if (k != o && r[k]) oth = 1;
      if (!r[o] || !l[o] || (m_hold >= MAXH - 1 && oth)) begin
        m_rr = (o + 1) % 3;
        nxt  = -1;
        for (int n = 0; n < 3; n++) begin
          j = (m_rr + n) % 3;
          if (nxt < 0 && j != o && r[j]) nxt = j;
        end
        m_owner = nxt;
        m_hold  = 0;
      end else begin
        m_hold++;
      end
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  function automatic logic [3*AW-1:0] pa(input int a0, input int a1, input int a2);
    return {AW'(a2), AW'(a1), AW'(a0)};
  endfunction

  function automatic logic [3*DW-1:0] pd(input int d0, input int d1, input int d2);
    return {DW'(d2), DW'(d1), DW'(d0)};
  endfunction

  task automatic idle_step();
    step(3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, '0, '0, '0, '0);
  endtask

  // Synchronous-to-bench reset pulse of one cycle.
  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    idle_step();
    rst = 1'b0;
  endtask

  task automatic rand_step();
    logic [3*AW-1:0] aa, ab;
    for (int i = 0; i < 3; i++) begin
      aa[i*AW +: AW] = AW'($urandom_range(0, 7));
      ab[i*AW +: AW] = AW'($urandom_range(0, 7));
      if ($urandom_range(0, 19) == 0) aa[i*AW +: AW] = AW'($urandom);
    end
    step(3'($urandom), 3'($urandom | $urandom), 3'($urandom), 3'($urandom),
         3'($urandom), 3'($urandom), aa, ab, (3*DW)'($urandom), (3*DW)'($urandom));
  endtask

  logic [2:0] seq [4];
  int         cnt;
  bit         moved;

  initial begin
    for (int i = 0; i < 4096; i++) begin
      sram[i]    = '0;
      ref_mem[i] = '0;
    end
    model_reset();

    // 1: reset with every request and enable asserted.
    req = 3'b111; lock = 3'b111; rd_a_in = 3'b111; rd_b_in = 3'b111;
    wr_a_in = 3'b111; wr_b_in = 3'b111;
    addr_a_in = pa(1, 2, 3); addr_b_in = pa(4, 5, 6);
    wdata_a_in = pd(7, 8, 9); wdata_b_in = pd(10, 11, 12);
    #1;
    chk("reset_gnt", 64'(gnt), 64'd0);
    chk("reset_rvalid", 64'(rvalid), 64'd0);
    chk("reset_enables", 64'({rden_a, rden_b, wren_a, wren_b}), 64'd0);
    chk("reset_collision", 64'(collision_err), 64'd0);
    step(3'b111, 3'b111, 3'b111, 3'b111, 3'b111, 3'b111, pa(1, 2, 3), pa(4, 5, 6),
         pd(7, 8, 9), pd(10, 11, 12));
    rst = 1'b0;

    // 2: requester 0 writes 0x3C at 5, requester 2 reads it back.
    step(3'b001, 3'b000, 3'b000, 3'b000, 3'b001, 3'b000, pa(5, 0, 0), '0, pd(8'h3C, 0, 0), '0);
    step(3'b001, 3'b000, 3'b000, 3'b000, 3'b001, 3'b000, pa(5, 0, 0), '0, pd(8'h3C, 0, 0), '0);
    chk("write_gnt", 64'(last_gnt), 64'b001);
    step(3'b100, 3'b000, 3'b100, 3'b000, 3'b000, 3'b000, pa(0, 0, 5), '0, '0, '0);
    step(3'b100, 3'b000, 3'b100, 3'b000, 3'b000, 3'b000, pa(0, 0, 5), '0, '0, '0);
    chk("read_gnt", 64'(last_gnt), 64'b100);
    idle_step();
    idle_step();

    // 3: all requesting without lock rotates every cycle.
    do_reset();
    step(3'b111, 3'b000, '0, '0, '0, '0, '0, '0, '0, '0);
    for (int i = 0; i < 4; i++) begin
      step(3'b111, 3'b000, '0, '0, '0, '0, '0, '0, '0, '0);
      seq[i] = last_gnt;
    end
    chk("rr_seq0", 64'(seq[0]), 64'b001);
    chk("rr_seq1", 64'(seq[1]), 64'b010);
    chk("rr_seq2", 64'(seq[2]), 64'b100);
    chk("rr_seq3", 64'(seq[3]), 64'b001);

    // 4: locked owner forced off after MAX_HOLD cycles once another request appears.
    do_reset();
    cnt = 0;
    moved = 0;
    for (int i = 0; i < 11; i++) begin
      step(3'b010, 3'b010, '0, '0, '0, '0, '0, '0, '0, '0);
      if (last_gnt == 3'b010) cnt++;
    end
    for (int i = 0; i < 300 && !moved; i++) begin
      step(3'b011, 3'b010, '0, '0, '0, '0, '0, '0, '0, '0);
      if (last_gnt == 3'b010) cnt++;
      if (last_gnt == 3'b001) moved = 1;
    end
    chk("hold_len", 64'(cnt), 64'(MAXH));
    chk("hold_handover", 64'(moved), 64'd1);

    // 5: same-address double write, port A wins, sticky error.
    do_reset();
    step(3'b001, 3'b001, '0, '0, 3'b001, 3'b001, pa(100, 0, 0), pa(100, 0, 0),
         pd(8'h11, 0, 0), pd(8'h22, 0, 0));
    step(3'b001, 3'b001, '0, '0, 3'b001, 3'b001, pa(100, 0, 0), pa(100, 0, 0),
         pd(8'h11, 0, 0), pd(8'h22, 0, 0));
    step(3'b001, 3'b001, 3'b001, '0, '0, '0, pa(100, 0, 0), '0, '0, '0);
    idle_step();
    idle_step();
    chk("collision_sticky", 64'(collision_err), 64'd1);
    do_reset();
    chk("collision_cleared", 64'(collision_err), 64'd0);

    // 6: asynchronous reset in the middle of a locked read grant.
    step(3'b100, 3'b100, 3'b100, '0, '0, '0, pa(0, 0, 5), '0, '0, '0);
    step(3'b100, 3'b100, 3'b100, '0, '0, '0, pa(0, 0, 5), '0, '0, '0);
    step(3'b100, 3'b100, 3'b100, '0, '0, '0, pa(0, 0, 5), '0, '0, '0);
    chk("pre_rst_rvalid", 64'(rvalid), 64'b100);
    #1 rst = 1'b1;
    #1;
    chk("async_gnt", 64'(gnt), 64'd0);
    chk("async_rden_a", 64'(rden_a), 64'd0);
    chk("async_rvalid", 64'(rvalid), 64'd0);
    model_reset();
    step(3'b100, 3'b100, 3'b100, '0, '0, '0, pa(0, 0, 5), '0, '0, '0);
    rst = 1'b0;
    step(3'b100, 3'b000, '0, '0, '0, '0, '0, '0, '0, '0);
    step(3'b100, 3'b000, '0, '0, '0, '0, '0, '0, '0, '0);
    chk("post_rst_gnt", 64'(last_gnt), 64'b100);
    idle_step();

    // Random traffic against the model.
    for (int i = 0; i < 2000; i++) rand_step();
    idle_step();
    idle_step();
    chk("sb_drained", 64'(sb.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end

endmodule
